// File: rtl/wb_dma_irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// wb_dma_irq_ctrl_if
// Wishbone slave bus bundle for wb_dma_irq_ctrl.
//   wb_addr_i  : byte address (master -> slave)
//   wb_data_i  : write data   (master -> slave)
//   wb_we_i    : write enable (master -> slave)
//   wb_stb_i   : strobe       (master -> slave)
//   wb_cyc_i   : cycle valid  (master -> slave)
//   wb_data_o  : read data, valid only while wb_ack_o=1 (slave -> master)
//   wb_ack_o   : single-cycle acknowledge (slave -> master)
// -----------------------------------------------------------------------------
interface wb_dma_irq_ctrl_if #(
   parameter int AW = 17,
   parameter int DW = 32
);
   logic [AW-1:0] wb_addr_i;
   logic [DW-1:0] wb_data_i;
   logic          wb_we_i;
   logic          wb_stb_i;
   logic          wb_cyc_i;
   logic [DW-1:0] wb_data_o;
   logic          wb_ack_o;

   modport master (
      output wb_addr_i, wb_data_i, wb_we_i, wb_stb_i, wb_cyc_i,
      input  wb_data_o, wb_ack_o
   );

   modport slave (
      input  wb_addr_i, wb_data_i, wb_we_i, wb_stb_i, wb_cyc_i,
      output wb_data_o, wb_ack_o
   );
endinterface

// File: rtl/wb_dma_irq_ctrl.sv
// -----------------------------------------------------------------------------
// wb_dma_irq_ctrl
// Wishbone register slave for the USB function core: control/status registers,
// NCH DMA request channels with 16-bit transfer counters, two maskable
// interrupt outputs and suspend/resume control. Single clock domain (wb_clk).
//
// Ports:
//   wb_clk        : clock
//   wb_rst        : asynchronous reset, active high
//   bus           : Wishbone slave bundle (addr/data/we/stb/cyc in, data/ack out)
//   dma_req_o     : per-channel DMA request (count != 0 and not suspended)
//   dma_ack_i     : per-channel one-cycle ack pulse, one pulse per transfer
//   inta_o/intb_o : registered |(STATUS & INTx_MASK)
//   susp_o        : suspend request (CTRL.SUSP)
//   resume_req_i  : resume request, acts on its rising edge
//
// Register map (byte offsets, decoded from addr[7:2]):
//   0x00 CTRL (bit0 SUSP), 0x04 STATUS (W1C, [NCH-1:0] done, bit16 resume),
//   0x08 INTA_MASK, 0x0C INTB_MASK, 0x40+4n CH_CNT[n] (bits[15:0]).
// -----------------------------------------------------------------------------
module wb_dma_irq_ctrl #(
   parameter int AW          = 17,
   parameter int DW          = 32,
   parameter int NCH         = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic             wb_clk,
   input  logic             wb_rst,
   wb_dma_irq_ctrl_if.slave bus,
   output logic [NCH-1:0]   dma_req_o,
   input  logic [NCH-1:0]   dma_ack_i,
   output logic             inta_o,
   output logic             intb_o,
   output logic             susp_o,
   input  logic             resume_req_i
);

   localparam logic [2:0]  WS_LAST   = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
   // Implemented STATUS/mask bits: channel done flags plus the resume flag.
   localparam logic [16:0] STAT_IMPL = {1'b1, 16'((32'h1 << NCH) - 32'h1)};

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t        r_state, w_state_nxt;
   logic [2:0]    r_wcnt, w_wcnt_nxt;
   logic [5:0]    r_adr;
   logic [16:0]   r_dat;
   logic          r_we;

   logic          r_susp;
   logic [16:0]   r_status, r_inta_mask, r_intb_mask;
   logic [15:0]   r_cnt [NCH];
   logic          r_resume_d;
   logic          r_inta, r_intb;

   logic          w_req, w_ack, w_wr;
   logic          w_wr_ctrl, w_wr_stat, w_wr_ma, w_wr_mb;
   logic [NCH-1:0] w_cnt_wr, w_ack_ok, w_done;
   logic          w_resume_rise;
   logic [16:0]   w_stat_set, w_stat_clr;
   logic [DW-1:0] w_rdata;

   // Address/data bits outside the decoded range are intentionally ignored.
   logic w_unused;
   assign w_unused = &{1'b0, bus.wb_addr_i[AW-1:8], bus.wb_addr_i[1:0],
                       bus.wb_data_i[DW-1:17]};

   assign w_req = bus.wb_cyc_i & bus.wb_stb_i;

   // Bus FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      w_wcnt_nxt  = r_wcnt;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               w_wcnt_nxt  = '0;
               w_state_nxt = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
            end
         end
         S_WAIT: begin
            // Master withdrew the request: abandon silently.
            if (!w_req)                 w_state_nxt = S_IDLE;
            else if (r_wcnt == WS_LAST) w_state_nxt = S_ACK;
            else                        w_wcnt_nxt  = r_wcnt + 3'd1;
         end
         S_ACK:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Bus FSM: state register and request capture
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         r_state <= S_IDLE;
         r_wcnt  <= '0;
         r_adr   <= '0;
         r_dat   <= '0;
         r_we    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_wcnt  <= w_wcnt_nxt;
         if (r_state == S_IDLE && w_req) begin
            r_adr <= bus.wb_addr_i[7:2];
            r_dat <= bus.wb_data_i[16:0];
            r_we  <= bus.wb_we_i;
         end
      end
   end

   assign w_ack     = (r_state == S_ACK);
   assign w_wr      = w_ack & r_we;
   assign w_wr_ctrl = w_wr & (r_adr == 6'd0);
   assign w_wr_stat = w_wr & (r_adr == 6'd1);
   assign w_wr_ma   = w_wr & (r_adr == 6'd2);
   assign w_wr_mb   = w_wr & (r_adr == 6'd3);

   assign w_resume_rise = resume_req_i & ~r_resume_d;

   // Channel decode: a register write to CH_CNT[n] masks a same-cycle ack.
   always_comb begin
      for (int n = 0; n < NCH; n++) begin
         w_cnt_wr[n]  = w_wr & (r_adr == 6'(16 + n));
         w_ack_ok[n]  = dma_ack_i[n] & (r_cnt[n] != 16'd0) & ~r_susp & ~w_cnt_wr[n];
         w_done[n]    = w_ack_ok[n] & (r_cnt[n] == 16'd1);
         dma_req_o[n] = (r_cnt[n] != 16'd0) & ~r_susp;
      end
   end

   // Set terms are OR-ed after the W1C clear so a same-cycle set wins.
   assign w_stat_set = {w_resume_rise, 16'(w_done)};
   assign w_stat_clr = w_wr_stat ? r_dat : 17'd0;

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         r_susp      <= 1'b0;
         r_status    <= '0;
         r_inta_mask <= '0;
         r_intb_mask <= '0;
         r_resume_d  <= 1'b0;
         r_inta      <= 1'b0;
         r_intb      <= 1'b0;
         for (int n = 0; n < NCH; n++) r_cnt[n] <= '0;
      end else begin
         r_resume_d <= resume_req_i;
         // Resume edge overrides a coincident SUSP write.
         if (w_resume_rise)  r_susp <= 1'b0;
         else if (w_wr_ctrl) r_susp <= r_dat[0];
         r_status <= ((r_status & ~w_stat_clr) | w_stat_set) & STAT_IMPL;
         if (w_wr_ma) r_inta_mask <= r_dat & STAT_IMPL;
         if (w_wr_mb) r_intb_mask <= r_dat & STAT_IMPL;
         r_inta <= |(r_status & r_inta_mask);
         r_intb <= |(r_status & r_intb_mask);
         for (int n = 0; n < NCH; n++) begin
            if (w_cnt_wr[n])      r_cnt[n] <= r_dat[15:0];
            else if (w_ack_ok[n]) r_cnt[n] <= r_cnt[n] - 16'd1;
         end
      end
   end

   // Read mux, driven only in the ack cycle
   always_comb begin
      w_rdata = '0;
      case (r_adr)
         6'd0: w_rdata[0]    = r_susp;
         6'd1: w_rdata[16:0] = r_status;
         6'd2: w_rdata[16:0] = r_inta_mask;
         6'd3: w_rdata[16:0] = r_intb_mask;
         default: begin
            for (int n = 0; n < NCH; n++)
               if (r_adr == 6'(16 + n)) w_rdata[15:0] = r_cnt[n];
         end
      endcase
   end

   assign bus.wb_ack_o  = w_ack;
   assign bus.wb_data_o = w_ack ? w_rdata : '0;
   assign inta_o        = r_inta;
   assign intb_o        = r_intb;
   assign susp_o        = r_susp;

endmodule

// File: tb/tb_wb_dma_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_dma_irq_ctrl
// Directed bench: one DUT with WAIT_STATES=0 (dut0) and one with
// WAIT_STATES=3 (dut3) sharing clock, reset and the bus address/data lines;
// each has its own strobe so only one is addressed at a time.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_dma_irq_ctrl;
   localparam int NCH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [16:0]    addr = '0;
   logic [31:0]    wdat = '0;
   logic           we   = 1'b0;
   logic           cyc  = 1'b0;
   logic           stb0 = 1'b0;
   logic           stb3 = 1'b0;
   logic [NCH-1:0] dma_ack0 = '0;
   logic [NCH-1:0] dma_ack3 = '0;
   logic           resume0 = 1'b0;
   logic           resume3 = 1'b0;
   logic [NCH-1:0] req0, req3;
   logic           inta0, intb0, susp0, inta3, intb3, susp3;

   int vecs = 0;
   int errs = 0;

   wb_dma_irq_ctrl_if #(.AW(17), .DW(32)) bus0 ();
   wb_dma_irq_ctrl_if #(.AW(17), .DW(32)) bus3 ();

   assign bus0.wb_addr_i = addr;
   assign bus0.wb_data_i = wdat;
   assign bus0.wb_we_i   = we;
   assign bus0.wb_cyc_i  = cyc;
   assign bus0.wb_stb_i  = stb0;
   assign bus3.wb_addr_i = addr;
   assign bus3.wb_data_i = wdat;
   assign bus3.wb_we_i   = we;
   assign bus3.wb_cyc_i  = cyc;
   assign bus3.wb_stb_i  = stb3;

   wb_dma_irq_ctrl #(.AW(17), .DW(32), .NCH(NCH), .WAIT_STATES(0)) dut0 (
      .wb_clk(clk), .wb_rst(rst), .bus(bus0.slave),
      .dma_req_o(req0), .dma_ack_i(dma_ack0),
      .inta_o(inta0), .intb_o(intb0), .susp_o(susp0), .resume_req_i(resume0));

   wb_dma_irq_ctrl #(.AW(17), .DW(32), .NCH(NCH), .WAIT_STATES(3)) dut3 (
      .wb_clk(clk), .wb_rst(rst), .bus(bus3.slave),
      .dma_req_o(req3), .dma_ack_i(dma_ack3),
      .inta_o(inta3), .intb_o(intb3), .susp_o(susp3), .resume_req_i(resume3));

   // One bus access; lat = cycles from sample edge to observed ack, -1 on timeout.
   task automatic bus_xfer(input int sel, input logic w, input logic [16:0] a,
                           input logic [31:0] d, output logic [31:0] rd, output int lat);
      logic ackv;
      @(posedge clk); #1;
      addr = a; wdat = d; we = w; cyc = 1'b1;
      if (sel == 0) stb0 = 1'b1; else stb3 = 1'b1;
      lat = -1; rd = '0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         ackv = (sel == 0) ? bus0.wb_ack_o : bus3.wb_ack_o;
         if (ackv) begin
            lat = i;
            rd  = (sel == 0) ? bus0.wb_data_o : bus3.wb_data_o;
            break;
         end
      end
      cyc = 1'b0; stb0 = 1'b0; stb3 = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input int sel, input logic [16:0] a, input logic [31:0] d);
      logic [31:0] rd;
      int lat;
      bus_xfer(sel, 1'b1, a, d, rd, lat);
   endtask

   task automatic pulse0(input logic [NCH-1:0] m);
      @(posedge clk); #1 dma_ack0 = m;
      @(posedge clk); #1 dma_ack0 = '0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      int lat;
      logic [16:0] addrs [4];
      addrs[0] = 17'h00; addrs[1] = 17'h04; addrs[2] = 17'h08; addrs[3] = 17'h40;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      vecs++; if (req0 !== 16'h0) begin errs++; $display("FAIL rst_req got %h exp 0", req0); end
      vecs++; if (inta0 !== 1'b0 || intb0 !== 1'b0) begin errs++; $display("FAIL rst_int got %b%b exp 00", inta0, intb0); end
      vecs++; if (susp0 !== 1'b0) begin errs++; $display("FAIL rst_susp got %b exp 0", susp0); end
      vecs++; if (bus0.wb_ack_o !== 1'b0) begin errs++; $display("FAIL rst_ack got %b exp 0", bus0.wb_ack_o); end
      for (int i = 0; i < 4; i++) begin
         bus_xfer(0, 1'b0, addrs[i], 32'h0, rd, lat);
         vecs++; if (lat !== 1) begin errs++; $display("FAIL rst_rd_lat a=%h got %0d exp 1", addrs[i], lat); end
         vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL rst_rd_data a=%h got %h exp 0", addrs[i], rd); end
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] rd;
      int lat;
      logic seen;
      bus_xfer(3, 1'b1, 17'h40, 32'd3, rd, lat);
      vecs++; if (lat !== 4) begin errs++; $display("FAIL ws3_wr_lat got %0d exp 4", lat); end
      // Second write of 7, withdrawn in the 2nd WAIT cycle.
      @(posedge clk); #1;
      addr = 17'h40; wdat = 32'd7; we = 1'b1; cyc = 1'b1; stb3 = 1'b1;
      @(posedge clk); #1 seen = bus3.wb_ack_o;
      @(posedge clk); #1 seen = seen | bus3.wb_ack_o;
      stb3 = 1'b0; cyc = 1'b0; we = 1'b0;
      repeat (6) begin
         @(posedge clk); #1 seen = seen | bus3.wb_ack_o;
      end
      vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL ws3_abort_ack got %b exp 0", seen); end
      bus_xfer(3, 1'b0, 17'h40, 32'h0, rd, lat);
      vecs++; if (lat !== 4) begin errs++; $display("FAIL ws3_rd_lat got %0d exp 4", lat); end
      vecs++; if (rd !== 32'd3) begin errs++; $display("FAIL ws3_cnt0 got %h exp 3", rd); end
   endtask

   task automatic test_channel_done();
      logic [31:0] rd;
      int lat;
      wr(0, 17'h40, 32'd3);
      wr(0, 17'h08, 32'h1);
      @(posedge clk); #1;
      vecs++; if (req0[0] !== 1'b1) begin errs++; $display("FAIL ch0_req_on got %b exp 1", req0[0]); end
      pulse0(16'h0001);
      pulse0(16'h0001);
      vecs++; if (req0[0] !== 1'b1) begin errs++; $display("FAIL ch0_req_after2 got %b exp 1", req0[0]); end
      pulse0(16'h0001);
      vecs++; if (req0[0] !== 1'b0) begin errs++; $display("FAIL ch0_req_off got %b exp 0", req0[0]); end
      vecs++; if (inta0 !== 1'b0) begin errs++; $display("FAIL ch0_inta_early got %b exp 0", inta0); end
      @(posedge clk); #1;
      vecs++; if (inta0 !== 1'b1) begin errs++; $display("FAIL ch0_inta got %b exp 1", inta0); end
      vecs++; if (intb0 !== 1'b0) begin errs++; $display("FAIL ch0_intb got %b exp 0", intb0); end
      bus_xfer(0, 1'b0, 17'h04, 32'h0, rd, lat);
      vecs++; if (rd !== 32'h1) begin errs++; $display("FAIL ch0_status got %h exp 1", rd); end
      bus_xfer(0, 1'b0, 17'h40, 32'h0, rd, lat);
      vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL ch0_cnt got %h exp 0", rd); end
      wr(0, 17'h04, 32'h1);
      @(posedge clk);
      @(posedge clk); #1;
      vecs++; if (inta0 !== 1'b0) begin errs++; $display("FAIL ch0_inta_clr got %b exp 0", inta0); end
      bus_xfer(0, 1'b0, 17'h04, 32'h0, rd, lat);
      vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL ch0_status_clr got %h exp 0", rd); end
   endtask

   task automatic test_collision();
      logic [31:0] rd;
      int lat;
      wr(0, 17'h48, 32'd5);
      // Write 9 to CH_CNT[2] with dma_ack_i[2] in the ack (commit) cycle.
      @(posedge clk); #1;
      addr = 17'h48; wdat = 32'd9; we = 1'b1; cyc = 1'b1; stb0 = 1'b1;
      @(posedge clk); #1;
      vecs++; if (bus0.wb_ack_o !== 1'b1) begin errs++; $display("FAIL coll_ack got %b exp 1", bus0.wb_ack_o); end
      dma_ack0 = 16'h0004;
      @(posedge clk); #1;
      dma_ack0 = '0; cyc = 1'b0; stb0 = 1'b0; we = 1'b0;
      bus_xfer(0, 1'b0, 17'h48, 32'h0, rd, lat);
      vecs++; if (rd !== 32'd9) begin errs++; $display("FAIL coll_cnt got %0d exp 9", rd); end
      wr(0, 17'h48, 32'd3);
      pulse0(16'h0004); pulse0(16'h0004); pulse0(16'h0004);
      pulse0(16'h0004);
      bus_xfer(0, 1'b0, 17'h48, 32'h0, rd, lat);
      vecs++; if (rd !== 32'd0) begin errs++; $display("FAIL ch2_no_wrap got %h exp 0", rd); end
      vecs++; if (req0[2] !== 1'b0) begin errs++; $display("FAIL ch2_req got %b exp 0", req0[2]); end
      bus_xfer(0, 1'b0, 17'h04, 32'h0, rd, lat);
      vecs++; if (rd !== 32'h4) begin errs++; $display("FAIL ch2_status got %h exp 4", rd); end
      // Writing 0 to a non-zero count must not flag done.
      wr(0, 17'h04, 32'h4);
      wr(0, 17'h4C, 32'd5);
      wr(0, 17'h4C, 32'd0);
      bus_xfer(0, 1'b0, 17'h04, 32'h0, rd, lat);
      vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL wr0_status got %h exp 0", rd); end
      // Done set and W1C of the same bit in one cycle: set wins.
      wr(0, 17'h40, 32'd1);
      @(posedge clk); #1;
      addr = 17'h04; wdat = 32'h1; we = 1'b1; cyc = 1'b1; stb0 = 1'b1;
      @(posedge clk); #1 dma_ack0 = 16'h0001;
      @(posedge clk); #1;
      dma_ack0 = '0; cyc = 1'b0; stb0 = 1'b0; we = 1'b0;
      bus_xfer(0, 1'b0, 17'h04, 32'h0, rd, lat);
      vecs++; if (rd !== 32'h1) begin errs++; $display("FAIL set_vs_w1c got %h exp 1", rd); end
      wr(0, 17'h04, 32'h1);
      // Unimplemented offset reads 0, still acked.
      bus_xfer(0, 1'b0, 17'h10, 32'h0, rd, lat);
      vecs++; if (lat !== 1 || rd !== 32'h0) begin errs++; $display("FAIL unimpl got lat=%0d d=%h exp lat=1 d=0", lat, rd); end
   endtask

   task automatic test_suspend();
      logic [31:0] rd;
      int lat;
      wr(0, 17'h0C, 32'h10000);
      wr(0, 17'h44, 32'd2);
      wr(0, 17'h00, 32'h1);
      @(posedge clk); #1;
      vecs++; if (susp0 !== 1'b1) begin errs++; $display("FAIL susp_on got %b exp 1", susp0); end
      vecs++; if (req0[1] !== 1'b0) begin errs++; $display("FAIL susp_req got %b exp 0", req0[1]); end
      pulse0(16'h0002);
      bus_xfer(0, 1'b0, 17'h44, 32'h0, rd, lat);
      vecs++; if (rd !== 32'd2) begin errs++; $display("FAIL susp_cnt got %0d exp 2", rd); end
      bus_xfer(0, 1'b0, 17'h00, 32'h0, rd, lat);
      vecs++; if (rd !== 32'h1) begin errs++; $display("FAIL ctrl_rd got %h exp 1", rd); end
      @(posedge clk); #1 resume0 = 1'b1;
      @(posedge clk); #1;
      vecs++; if (susp0 !== 1'b0) begin errs++; $display("FAIL resume_susp got %b exp 0", susp0); end
      vecs++; if (req0[1] !== 1'b1) begin errs++; $display("FAIL resume_req got %b exp 1", req0[1]); end
      vecs++; if (intb0 !== 1'b0) begin errs++; $display("FAIL intb_early got %b exp 0", intb0); end
      @(posedge clk); #1;
      vecs++; if (intb0 !== 1'b1) begin errs++; $display("FAIL intb got %b exp 1", intb0); end
      bus_xfer(0, 1'b0, 17'h04, 32'h0, rd, lat);
      vecs++; if (rd !== 32'h10000) begin errs++; $display("FAIL resume_status got %h exp 10000", rd); end
      // SUSP write coinciding with a resume edge: resume wins.
      resume0 = 1'b0;
      @(posedge clk); #1;
      addr = 17'h00; wdat = 32'h1; we = 1'b1; cyc = 1'b1; stb0 = 1'b1;
      @(posedge clk); #1 resume0 = 1'b1;
      @(posedge clk); #1;
      cyc = 1'b0; stb0 = 1'b0; we = 1'b0;
      vecs++; if (susp0 !== 1'b0) begin errs++; $display("FAIL resume_vs_wr got %b exp 0", susp0); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      int lat;
      logic seen;
      @(posedge clk); #1;
      addr = 17'h40; wdat = 32'd5; we = 1'b1; cyc = 1'b1; stb3 = 1'b1;
      dma_ack0 = 16'h0002;
      @(posedge clk);
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      vecs++; if (req0 !== 16'h0 || req3 !== 16'h0) begin errs++; $display("FAIL mid_rst_req got %h/%h exp 0/0", req0, req3); end
      vecs++; if ({inta0, intb0, susp0} !== 3'b000) begin errs++; $display("FAIL mid_rst_outs got %b exp 000", {inta0, intb0, susp0}); end
      seen = bus3.wb_ack_o | bus0.wb_ack_o;
      repeat (3) begin
         @(posedge clk); #1 seen = seen | bus3.wb_ack_o;
      end
      vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL mid_rst_ack got %b exp 0", seen); end
      cyc = 1'b0; stb3 = 1'b0; we = 1'b0; dma_ack0 = '0; resume0 = 1'b0;
      rst = 1'b0;
      bus_xfer(3, 1'b0, 17'h40, 32'h0, rd, lat);
      vecs++; if (lat !== 4) begin errs++; $display("FAIL post_rst_lat3 got %0d exp 4", lat); end
      vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL post_rst_cnt got %h exp 0", rd); end
      bus_xfer(0, 1'b0, 17'h04, 32'h0, rd, lat);
      vecs++; if (lat !== 1 || rd !== 32'h0) begin errs++; $display("FAIL post_rst_status got lat=%0d d=%h exp lat=1 d=0", lat, rd); end
   endtask

   initial begin
      test_reset();
      test_wait_states();
      test_channel_done();
      test_collision();
      test_suspend();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/wb_dma_irq_ctrl.md
Name: wb_dma_irq_ctrl

Overview:
- Parametrised Wishbone slave for the USB function core: register file, NCH DMA request channels, dual interrupt routing and suspend/resume control.
- Replaces the fixed 16-channel, zero-wait, signal-only Wishbone interface with a real register map, per-channel transfer counters, configurable ack latency and maskable inta/intb outputs.
- Sits between the host Wishbone bus and the USB endpoint/DMA logic in the wb_clk domain.

Parameters:
- AW, 17, Wishbone address width; decode uses wb_addr_i[7:2] only.
- DW, 32, Wishbone data width; must be 32.
- NCH, 16, DMA channel count; legal range 1..16.
- WAIT_STATES, 0, extra cycles between request sample and wb_ack_o; legal range 0..7.

Ports:
- wb_clk  in  1  clock.
- wb_rst  in  1  asynchronous reset, active high.
- wb_addr_i  in  AW  byte address.
- wb_data_i  in  DW  write data.
- wb_data_o  out  DW  read data; valid only while wb_ack_o=1.
- wb_we_i  in  1  write enable.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle valid.
- wb_ack_o  out  1  single-cycle acknowledge.
- dma_req_o  out  NCH  per-channel DMA request.
- dma_ack_i  in  NCH  per-channel one-cycle ack pulse; one pulse = one transfer.
- inta_o  out  1  interrupt A.
- intb_o  out  1  interrupt B.
- susp_o  out  1  suspend request to the USB core.
- resume_req_i  in  1  resume request; acts on its rising edge.

Behaviour:
- Reset: all registers, counters and outputs go to 0; the bus FSM goes to IDLE. Reset during a bus cycle drops it with no ack and no write.
- Register map (offset, access, content):
  - 0x00 CTRL, RW: bit0 = SUSP.
  - 0x04 STATUS, W1C: bits[NCH-1:0] = channel done flags; bit16 = RESUME flag.
  - 0x08 INTA_MASK, RW: same bit layout as STATUS.
  - 0x0C INTB_MASK, RW: same bit layout as STATUS.
  - 0x40+4n CH_CNT[n], RW: bits[15:0] = remaining transfer count.
  - Unimplemented bits and offsets read 0; writes to them are ignored but still acked.
- Bus FSM states IDLE, WAIT, ACK:
  - IDLE -> WAIT when wb_cyc_i & wb_stb_i. The address, data and we captured in that cycle are used for the whole access.
  - WAIT counts WAIT_STATES cycles, then -> ACK. With WAIT_STATES=0, IDLE goes directly to ACK.
  - ACK: wb_ack_o=1 for exactly one cycle; the write commits and read data is driven in this cycle; then -> IDLE.
  - Minimum access is 2 cycles (sample + ack). Back-to-back accesses: next request is sampled the cycle after ack.
  - If wb_cyc_i or wb_stb_i falls while in WAIT: return to IDLE, no ack, no write.
- Channel n:
  - dma_req_o[n] = (CH_CNT[n] != 0) & ~SUSP, decoded directly from registers with no extra latency.
  - dma_ack_i[n] while CH_CNT[n]>0 and SUSP=0 decrements the count by 1.
  - A decrement from 1 to 0 sets STATUS[n] on the next edge.
  - Acks are ignored when the count is 0 or SUSP=1.
  - Count is 16-bit, no wrap below 0.
- Simultaneous events:
  - CH_CNT[n] write in the same cycle as dma_ack_i[n]: the written value wins and the ack is dropped.
  - Writing 0 to CH_CNT[n] does not set STATUS[n].
  - STATUS set and a W1C of the same bit in one cycle: set wins.
- Suspend/resume:
  - susp_o = SUSP.
  - Rising edge of resume_req_i (previous-cycle sample 0, current sample 1) clears SUSP and sets STATUS[16].
  - If a CTRL write of SUSP=1 coincides with that edge, the resume wins.
- Interrupts:
  - inta_o registered each cycle from |(STATUS & INTA_MASK); intb_o likewise from |(STATUS & INTB_MASK).
  - One cycle latency from a STATUS or mask change.

Test Plan:
- Reset, then read 0x00, 0x04, 0x08 and 0x40 with WAIT_STATES=0 -> each ack arrives 1 cycle after sample, data 0; dma_req_o=0, inta_o=intb_o=0.
- WAIT_STATES=3: write 0x40 = 3; then drop stb in the 2nd WAIT cycle of a second write of 7 -> first ack 4 cycles after sample; second write has no ack; CH_CNT[0] reads 3.
- CH_CNT[0]=3, INTA_MASK=0x1, three dma_ack_i[0] pulses -> dma_req_o[0] falls after the 3rd pulse; STATUS=0x1 the next cycle; inta_o=1 one cycle later; write 0x04=0x1 -> inta_o=0.
- CH_CNT[2]=5, then write CH_CNT[2]=9 in the same cycle as dma_ack_i[2] -> reads 9; a 4th ack pulse sent while the count is 0 -> count stays 0, no error.
- CTRL=1 with CH_CNT[1]=2 -> susp_o=1, dma_req_o[1]=0, acks ignored; resume_req_i rising edge -> susp_o=0, STATUS[16]=1, intb_o=1 (INTB_MASK=0x10000).
- Assert wb_rst mid-WAIT and mid-transfer -> all outputs 0 immediately; no ack; after release the bus FSM is in IDLE.
